sdram_arb_mc: RTL and testbench
===============================

# sdram_arb_mc

Parametrised multi-channel SDRAM command arbiter, replacing the fixed write/read arbitration in the SDRAM top level. It multiplexes the init sequencer, the auto-refresh controller and NUM_CH user channels onto one SDRAM command/address/data bus. Refresh has absolute priority. User channels share the bus round-robin. A per-grant watchdog reclaims the bus from a channel that never signals completion.

## Interface
- NUM_CH, 4: number of user channels (1..8).
- ADDR_W, 12: SDRAM address width.
- BANK_W, 2: bank address width.
- DATA_W, 16: SDRAM DQ width.
- TIMEOUT, 1024: maximum cycles a channel may hold a grant (≥4).
- s_clk  in  1  system clock; all logic on rising edge.
- s_rst  in  1  reset, asynchronous, active-high.
- init_done  in  1  init sequencer finished; sampled only in INIT.
- init_cmd / init_addr / init_bank  in  4 / ADDR_W / BANK_W  init sequencer bus.
- aref_req  in  1  refresh controller request; level, held until serviced.
- aref_en  out  1  refresh grant.
- aref_end  in  1  refresh complete, 1-cycle pulse.
- aref_cmd / aref_addr / aref_bank  in  4 / ADDR_W / BANK_W  refresh bus.
- ch_req  in  NUM_CH  per-channel request level.
- ch_grant  out  NUM_CH  one-hot grant; all zero when no channel is granted.
- ch_end  in  NUM_CH  per-channel completion pulse.
- ch_wr  in  NUM_CH  channel drives DQ this cycle.
- ch_cmd  in  4*NUM_CH  packed commands; channel i is at [4i+3:4i].
- ch_addr / ch_bank / ch_wdata  in  ADDR_W / BANK_W / DATA_W ×NUM_CH  packed, same convention.
- sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- sdram_addr / sdram_bank  out  ADDR_W / BANK_W.
- sdram_dq_out  out  DATA_W  write data.
- sdram_dq_oe  out  1  DQ tristate enable.
- timeout_err  out  1  1-cycle pulse when the watchdog revokes a grant.

## Operation
- One-hot state register with states INIT, ARB, AREF, XFER.
- INIT → ARB when init_done=1. init_done is ignored in all other states.
- ARB, evaluated in priority order:
  - aref_req=1 → AREF; aref_en<=1 on the same edge.
  - else if any ch_req → XFER; ch_grant<=one-hot of the first requesting channel found scanning rr_ptr, rr_ptr+1, … mod NUM_CH.
  - else stay in ARB.
- AREF: aref_en stays 1. On aref_end=1 → ARB and aref_en<=0.
- XFER:
  - ch_end on the granted channel → ARB, ch_grant<=0, rr_ptr<=granted index+1 mod NUM_CH.
  - ch_end on non-granted channels is ignored.
  - Watchdog counter wd is cleared on XFER entry and increments each XFER cycle.
  - If wd==TIMEOUT-1 and the granted ch_end=0 → ARB, ch_grant<=0, timeout_err=1 for one cycle, rr_ptr advances as on a normal end.
  - If ch_end arrives in the same cycle that wd hits TIMEOUT-1, it is a normal end; no error.
- aref_req rising during XFER does not pre-empt the channel. It is serviced at the next ARB. Worst-case refresh latency is TIMEOUT+2 cycles.
- Bus mux (combinational from registered state):
  - INIT → init_* inputs.
  - ARB → NOP (4'b0111), addr 0, bank 0.
  - AREF → aref_* inputs.
  - XFER → the granted channel's cmd/addr/bank/wdata.
- sdram_dq_oe = (state==XFER) & ch_wr[granted]. sdram_dq_out is 0 when not in XFER.
- Reset values: state=INIT, aref_en=0, ch_grant=0, rr_ptr=0, wd=0, timeout_err=0, sdram_dq_oe=0. The bus outputs follow init_* while in reset.
- Reset mid-operation drops all grants immediately and returns to INIT. init_done must re-assert before arbitration resumes.

## Timing
- Grant latency: a request sampled in ARB at edge t gives grant/aref_en high after edge t; the mux switches in the same cycle.
- End to next grant: end seen at edge u gives ARB in cycle u+1 and the earliest new grant after edge u+1. This guarantees at least one NOP cycle between owners.
- A channel holds the bus for at most TIMEOUT cycles.
- rr_ptr wraps from NUM_CH-1 to 0.
- With NUM_CH=1 the round-robin degenerates to a fixed grant.

## Test plan
- Reset asserted 3 cycles, then init_done=1 at cycle 10 → state ARB at cycle 11; sdram_cmd=4'b0111; all grants 0.
- NUM_CH=4, rr_ptr=0, ch_req=4'b0110 held → grant order 0010, 0100, 0010…, each after the owner pulses ch_end. Between owners there is exactly one NOP cycle.
- aref_req and ch_req=4'b0001 both rise in the same ARB cycle → aref_en=1 and grant=0. After aref_end: ARB, then ch_grant=4'b0001.
- Channel 2 granted with ch_wr[2]=1 and ch_wdata[2]=16'hA5A5 → sdram_dq_oe=1 and sdram_dq_out=16'hA5A5 throughout XFER. sdram_dq_oe=0 in the ARB cycle that follows.
- TIMEOUT=8, channel 3 granted and never ends → grant drops after 8 cycles; timeout_err pulses once; the next requester, channel 0, is granted two cycles later.
- s_rst pulsed mid-XFER → ch_grant=0 and state=INIT immediately; no grant is issued until init_done re-asserts.

Source files
------------

// File: rtl/sdram_arb_mc.sv
// SDRAM command arbiter: multiplexes the init sequencer, the auto-refresh controller
// and NUM_CH round-robin user channels onto one SDRAM command/address/data bus.
module sdram_arb_mc #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 12,
  parameter int BANK_W  = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       s_clk,
  input  logic                       s_rst,
  input  logic                       init_done,
  input  logic [3:0]                 init_cmd,
  input  logic [ADDR_W-1:0]          init_addr,
  input  logic [BANK_W-1:0]          init_bank,
  input  logic                       aref_req,
  output logic                       aref_en,
  input  logic                       aref_end,
  input  logic [3:0]                 aref_cmd,
  input  logic [ADDR_W-1:0]          aref_addr,
  input  logic [BANK_W-1:0]          aref_bank,
  input  logic [NUM_CH-1:0]          ch_req,
  output logic [NUM_CH-1:0]          ch_grant,
  input  logic [NUM_CH-1:0]          ch_end,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [4*NUM_CH-1:0]        ch_cmd,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [BANK_W*NUM_CH-1:0]   ch_bank,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
  output logic [3:0]                 sdram_cmd,
  output logic [ADDR_W-1:0]          sdram_addr,
  output logic [BANK_W-1:0]          sdram_bank,
  output logic [DATA_W-1:0]          sdram_dq_out,
  output logic                       sdram_dq_oe,
  output logic                       timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [3:0]      CMD_NOP = 4'b0111;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT = 4'b0001,
    S_ARB  = 4'b0010,
    S_AREF = 4'b0100,
    S_XFER = 4'b1000
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_aref_en, w_aref_en_nxt;
  logic [NUM_CH-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_nxt;
  logic [WD_W-1:0]     r_wd, w_wd_nxt;
  logic                r_terr, w_terr_nxt;

  logic                w_pick_vld;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [IDX_W-1:0]    w_scan;
  logic [IDX_W-1:0]    w_inc_idx;
  logic                w_gnt_end;
  logic                w_wd_last;

  logic [3:0]          w_cmd_arr   [NUM_CH];
  logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
  logic [BANK_W-1:0]   w_bank_arr  [NUM_CH];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_cmd_arr[g]   = ch_cmd[4*g +: 4];
    assign w_addr_arr[g]  = ch_addr[ADDR_W*g +: ADDR_W];
    assign w_bank_arr[g]  = ch_bank[BANK_W*g +: BANK_W];
    assign w_wdata_arr[g] = ch_wdata[DATA_W*g +: DATA_W];
  end

  // Scan downwards so the channel closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (int'(r_rr_ptr) + k >= NUM_CH) w_scan = IDX_W'(int'(r_rr_ptr) + k - NUM_CH);
      else                              w_scan = IDX_W'(int'(r_rr_ptr) + k);
      if (ch_req[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_scan;
      end
    end
  end

  assign w_inc_idx = (int'(r_gidx) == NUM_CH - 1) ? '0 : r_gidx + 1'b1;
  assign w_gnt_end = ch_end[r_gidx];
  assign w_wd_last = (r_wd == WD_LAST);

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state   <= S_INIT;
      r_aref_en <= 1'b0;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_wd      <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aref_en <= w_aref_en_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_wd      <= w_wd_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_aref_en_nxt = r_aref_en;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_rr_nxt      = r_rr_ptr;
    w_wd_nxt      = r_wd;
    w_terr_nxt    = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (init_done) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (aref_req) begin
          w_state_nxt   = S_AREF;
          w_aref_en_nxt = 1'b1;
        end else if (w_pick_vld) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = NUM_CH'(1) << w_pick_idx;
          w_gidx_nxt  = w_pick_idx;
          w_wd_nxt    = '0;
        end
      end
      S_AREF: begin
        if (aref_end) begin
          w_state_nxt   = S_ARB;
          w_aref_en_nxt = 1'b0;
        end
      end
      S_XFER: begin
        // An end landing on the watchdog's last cycle still counts as a clean end.
        if (w_gnt_end || w_wd_last) begin
          w_state_nxt = S_ARB;
          w_grant_nxt = '0;
          w_rr_nxt    = w_inc_idx;
          w_wd_nxt    = '0;
          w_terr_nxt  = !w_gnt_end;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_INIT;
        w_aref_en_nxt = 1'b0;
        w_grant_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    unique case (r_state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = init_bank;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
        sdram_bank = aref_bank;
      end
      S_XFER: begin
        sdram_cmd    = w_cmd_arr[r_gidx];
        sdram_addr   = w_addr_arr[r_gidx];
        sdram_bank   = w_bank_arr[r_gidx];
        sdram_dq_out = w_wdata_arr[r_gidx];
        sdram_dq_oe  = ch_wr[r_gidx];
      end
      default: ;
    endcase
  end

  assign aref_en     = r_aref_en;
  assign ch_grant    = r_grant;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_sdram_arb_mc.sv
// Bench for sdram_arb_mc: directed stimulus, a phase-level reference model checked
// every cycle, and literal expectations at the key moments of each scenario.
module tb_sdram_arb_mc;
  localparam int NCH = 4, AW = 12, BW = 2, DW = 16, TMO = 8;

  logic            s_clk = 1'b0, s_rst = 1'b0, init_done = 1'b0;
  logic [3:0]      init_cmd = 4'h1, aref_cmd = 4'h2;
  logic [AW-1:0]   init_addr = 12'h0AB, aref_addr = 12'h400;
  logic [BW-1:0]   init_bank = 2'd1, aref_bank = 2'd2;
  logic            aref_req = 1'b0, aref_end = 1'b0, aref_en;
  logic [NCH-1:0]  ch_req = '0, ch_end = '0, ch_wr = '0, ch_grant;
  logic [4*NCH-1:0]  ch_cmd   = {4'h6, 4'h5, 4'h4, 4'h3};
  logic [AW*NCH-1:0] ch_addr  = {12'h333, 12'h222, 12'h111, 12'h010};
  logic [BW*NCH-1:0] ch_bank  = {2'd3, 2'd2, 2'd1, 2'd0};
  logic [DW*NCH-1:0] ch_wdata = {16'h3333, 16'hA5A5, 16'h1111, 16'h0F0F};
  logic [3:0]      sdram_cmd;
  logic [AW-1:0]   sdram_addr;
  logic [BW-1:0]   sdram_bank;
  logic [DW-1:0]   sdram_dq_out;
  logic            sdram_dq_oe, timeout_err;

  sdram_arb_mc #(.NUM_CH(NCH), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank),
    .aref_req(aref_req), .aref_en(aref_en), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_bank(aref_bank),
    .ch_req(ch_req), .ch_grant(ch_grant), .ch_end(ch_end), .ch_wr(ch_wr),
    .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_bank(ch_bank), .ch_wdata(ch_wdata),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .timeout_err(timeout_err)
  );

  always #5 s_clk = ~s_clk;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long they have held it, where the
  // round-robin search starts next.
  typedef enum int {M_INIT, M_ARB, M_AREF, M_XFER} mph_t;
  mph_t m_ph   = M_INIT;
  int   m_own  = 0;
  int   m_rr   = 0;
  int   m_held = 0;
  bit   m_terr = 1'b0;

  function automatic int pick(input logic [NCH-1:0] req, input int rr);
    for (int k = 0; k < NCH; k++)
      if (req[(rr + k) % NCH]) return (rr + k) % NCH;
    return 0;
  endfunction

  always @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      m_ph <= M_INIT; m_own <= 0; m_rr <= 0; m_held <= 0; m_terr <= 1'b0;
    end else begin
      m_terr <= 1'b0;
      case (m_ph)
        M_INIT: if (init_done) m_ph <= M_ARB;
        M_ARB: begin
          if (aref_req) m_ph <= M_AREF;
          else if (ch_req != '0) begin
            m_ph <= M_XFER; m_own <= pick(ch_req, m_rr); m_held <= 1;
          end
        end
        M_AREF: if (aref_end) m_ph <= M_ARB;
        M_XFER: begin
          if (ch_end[m_own]) begin
            m_ph <= M_ARB; m_rr <= (m_own + 1) % NCH;
          end else if (m_held == TMO) begin
            m_ph <= M_ARB; m_rr <= (m_own + 1) % NCH; m_terr <= 1'b1;
          end else m_held <= m_held + 1;
        end
        default: m_ph <= M_INIT;
      endcase
    end
  end

  logic [3:0] e_cmd; logic [AW-1:0] e_addr; logic [BW-1:0] e_bank;
  logic [DW-1:0] e_dq; logic e_oe, e_aref; logic [NCH-1:0] e_grant;

  always_comb begin
    e_cmd = 4'b0111; e_addr = '0; e_bank = '0; e_dq = '0; e_oe = 1'b0;
    e_grant = '0; e_aref = (m_ph == M_AREF);
    case (m_ph)
      M_INIT: begin e_cmd = init_cmd; e_addr = init_addr; e_bank = init_bank; end
      M_AREF: begin e_cmd = aref_cmd; e_addr = aref_addr; e_bank = aref_bank; end
      M_XFER: begin
        e_cmd   = 4'(ch_cmd >> (4 * m_own));
        e_addr  = AW'(ch_addr >> (AW * m_own));
        e_bank  = BW'(ch_bank >> (BW * m_own));
        e_dq    = DW'(ch_wdata >> (DW * m_own));
        e_oe    = ch_wr[m_own];
        e_grant = NCH'(1) << m_own;
      end
      default: ;
    endcase
  end

  always @(negedge s_clk) begin
    if (chk_on) begin
      chk("m_grant", ch_grant, e_grant);
      chk("m_aref_en", aref_en, e_aref);
      chk("m_cmd", sdram_cmd, e_cmd);
      chk("m_addr", sdram_addr, e_addr);
      chk("m_bank", sdram_bank, e_bank);
      chk("m_dq_oe", sdram_dq_oe, e_oe);
      chk("m_dq_out", sdram_dq_out, e_dq);
      chk("m_terr", timeout_err, m_terr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  initial begin
    #2 s_rst = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("rst_grant", ch_grant, 4'b0000);
    chk("rst_aref_en", aref_en, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_dq_oe", sdram_dq_oe, 1'b0);
    chk("rst_cmd", sdram_cmd, 4'h1);
    chk("rst_addr", sdram_addr, 12'h0AB);
    tick(3);
    s_rst = 1'b0;
    tick(6);
    init_done = 1'b1;
    @(negedge s_clk);
    chk("init_hold_cmd", sdram_cmd, 4'h1);
    tick(1);
    init_done = 1'b0;
    @(negedge s_clk);
    chk("arb_nop", sdram_cmd, 4'b0111);
    chk("arb_grant0", ch_grant, 4'b0000);

    // Round-robin between channels 1 and 2, with a write from channel 2.
    ch_req = 4'b0110;
    tick(1);
    @(negedge s_clk);
    chk("rr_first", ch_grant, 4'b0010);
    chk("rr_first_cmd", sdram_cmd, 4'h4);
    tick(1);
    ch_end = 4'b0010;
    tick(1);
    ch_end = '0;
    @(negedge s_clk);
    chk("nop_between", sdram_cmd, 4'b0111);
    chk("nop_grant", ch_grant, 4'b0000);
    ch_wr = 4'b0100;
    tick(1);
    @(negedge s_clk);
    chk("rr_second", ch_grant, 4'b0100);
    chk("wr_oe", sdram_dq_oe, 1'b1);
    chk("wr_data", sdram_dq_out, 16'hA5A5);
    tick(1);
    @(negedge s_clk);
    chk("wr_data2", sdram_dq_out, 16'hA5A5);
    ch_end = 4'b0100;
    tick(1);
    ch_end = '0;
    @(negedge s_clk);
    chk("wr_oe_off", sdram_dq_oe, 1'b0);
    ch_wr = '0;
    tick(1);
    @(negedge s_clk);
    chk("rr_wrap", ch_grant, 4'b0010);
    ch_end = 4'b0010; ch_req = '0;
    tick(1);
    ch_end = '0;

    // Refresh beats a simultaneous channel request.
    aref_req = 1'b1; ch_req = 4'b0001;
    tick(1);
    @(negedge s_clk);
    chk("aref_win", aref_en, 1'b1);
    chk("aref_nogrant", ch_grant, 4'b0000);
    chk("aref_cmd", sdram_cmd, 4'h2);
    tick(2);
    aref_end = 1'b1; aref_req = 1'b0;
    tick(1);
    aref_end = 1'b0;
    @(negedge s_clk);
    chk("aref_done", aref_en, 1'b0);
    chk("aref_done_cmd", sdram_cmd, 4'b0111);
    tick(1);
    @(negedge s_clk);
    chk("after_aref", ch_grant, 4'b0001);
    ch_end = 4'b0001; ch_req = '0;
    tick(1);
    ch_end = '0;

    // Watchdog: channel 3 never ends; a stray end from channel 0 is ignored.
    ch_req = 4'b1000;
    tick(1);
    @(negedge s_clk);
    chk("to_grant", ch_grant, 4'b1000);
    ch_req = 4'b1001;
    tick(2);
    ch_end = 4'b0001;
    tick(1);
    ch_end = '0;
    @(negedge s_clk);
    chk("ignore_other_end", ch_grant, 4'b1000);
    tick(4);
    @(negedge s_clk);
    chk("to_last_cycle", ch_grant, 4'b1000);
    chk("to_no_err_yet", timeout_err, 1'b0);
    tick(1);
    @(negedge s_clk);
    chk("to_drop", ch_grant, 4'b0000);
    chk("to_pulse", timeout_err, 1'b1);
    tick(1);
    @(negedge s_clk);
    chk("to_next", ch_grant, 4'b0001);
    chk("to_pulse_end", timeout_err, 1'b0);

    // End arriving on the watchdog's last cycle is a clean end.
    tick(7);
    ch_end = 4'b0001; ch_req = '0;
    tick(1);
    ch_end = '0;
    @(negedge s_clk);
    chk("end_at_limit_err", timeout_err, 1'b0);
    chk("end_at_limit_gnt", ch_grant, 4'b0000);

    // Refresh raised mid-transfer waits for the owner to finish.
    ch_req = 4'b0010;
    tick(1);
    aref_req = 1'b1;
    tick(2);
    @(negedge s_clk);
    chk("no_preempt_gnt", ch_grant, 4'b0010);
    chk("no_preempt_aref", aref_en, 1'b0);
    ch_end = 4'b0010; ch_req = '0;
    tick(1);
    ch_end = '0;
    tick(1);
    @(negedge s_clk);
    chk("aref_after_xfer", aref_en, 1'b1);
    aref_end = 1'b1; aref_req = 1'b0;
    tick(1);
    aref_end = 1'b0;

    // Asynchronous reset in the middle of a transfer.
    ch_req = 4'b0100;
    tick(1);
    @(negedge s_clk);
    chk("pre_rst_grant", ch_grant, 4'b0100);
    tick(1);
    s_rst = 1'b1;
    #1;
    chk("rst_async_gnt", ch_grant, 4'b0000);
    chk("rst_async_cmd", sdram_cmd, 4'h1);
    tick(1);
    s_rst = 1'b0;
    tick(3);
    @(negedge s_clk);
    chk("no_grant_in_init", ch_grant, 4'b0000);
    init_done = 1'b1;
    tick(1);
    init_done = 1'b0;
    @(negedge s_clk);
    chk("reinit_arb", ch_grant, 4'b0000);
    tick(1);
    @(negedge s_clk);
    chk("reinit_grant", ch_grant, 4'b0100);
    ch_end = 4'b0100; ch_req = '0;
    tick(1);
    ch_end = '0;
    tick(2);
    @(negedge s_clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
